// File: rtl/clk_rst_sequencer.sv
// Clock-generator bring-up sequencer: pulses MMCM_RST, waits for a stable lock, then releases the
// sys, symbol and serial domain resets in order and enables the DAC clock; lock loss restarts it.
module clk_rst_sequencer #(
   parameter int unsigned MMCM_RST_CYCLES    = 8,
   parameter int unsigned LOCK_TIMEOUT       = 4096,
   parameter int unsigned LOCK_STABLE_CYCLES = 256,
   parameter int unsigned STAGE_GAP          = 16,
   parameter int unsigned DAC_EN_DELAY       = 32,
   parameter int unsigned MAX_RETRY          = 3
) (
   input  logic       SYS_CLK,
   input  logic       A_GLB_RST_N,
   input  logic       LOCKED,
   input  logic       CLR_FAULT,
   output logic       MMCM_RST,
   output logic       SYS_RST_N,
   output logic       SYM_RST_N,
   output logic       SER_RST_N,
   output logic       DAC_CLK_ENABLE,
   output logic       CLK_READY,
   output logic       FAULT,
   output logic [7:0] LOSS_CNT
);

   localparam int unsigned Max0   = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES
                                                                      : LOCK_TIMEOUT;
   localparam int unsigned Max1   = (Max0 > LOCK_STABLE_CYCLES) ? Max0 : LOCK_STABLE_CYCLES;
   localparam int unsigned Max2   = (Max1 > STAGE_GAP) ? Max1 : STAGE_GAP;
   localparam int unsigned MaxCnt = (Max2 > DAC_EN_DELAY) ? Max2 : DAC_EN_DELAY;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);
   localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);

   localparam logic [CntW-1:0]   RstLast     = CntW'(MMCM_RST_CYCLES - 1);
   localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
   localparam logic [CntW-1:0]   StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CntW-1:0]   GapLast     = CntW'(STAGE_GAP - 1);
   // DAC_WAIT is entered one cycle after SER_RST_N rises, hence the extra cycle taken off.
   localparam logic [CntW-1:0]   DacLast     = CntW'(DAC_EN_DELAY - 2);
   localparam logic [CntW-1:0]   CntMax      = '1;
   localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);

   localparam logic [3:0] StRstAssert = 4'd0;
   localparam logic [3:0] StWaitLock  = 4'd1;
   localparam logic [3:0] StStable    = 4'd2;
   localparam logic [3:0] StRelSys    = 4'd3;
   localparam logic [3:0] StRelSym    = 4'd4;
   localparam logic [3:0] StRelSer    = 4'd5;
   localparam logic [3:0] StDacWait   = 4'd6;
   localparam logic [3:0] StRun       = 4'd7;
   localparam logic [3:0] StFault     = 4'd8;

   logic              lock_meta_q, lock_q;
   logic [3:0]        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [RetryW-1:0] retry_q, retry_d, retry_inc;
   logic [7:0]        loss_q, loss_d;
   logic              lost;
   logic              mmcm_rst_q, mmcm_rst_d;
   logic              sys_rst_n_q, sys_rst_n_d;
   logic              sym_rst_n_q, sym_rst_n_d;
   logic              ser_rst_n_q, ser_rst_n_d;
   logic              dac_en_q, dac_en_d;
   logic              ready_q, ready_d;
   logic              fault_q, fault_d;

   assign retry_inc = retry_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      retry_d = retry_q;
      loss_d  = loss_q;
      lost    = 1'b0;
      unique case (state_q)
         StRstAssert: if (cnt_q == RstLast) state_d = StWaitLock;
         StWaitLock: begin
            if (lock_q) begin
               state_d = StStable;
            end else if (cnt_q == TimeoutLast) begin
               retry_d = retry_inc;
               state_d = (retry_inc > RetryMax) ? StFault : StRstAssert;
            end
         end
         StStable: begin
            if (!lock_q) state_d = StWaitLock;
            else if (cnt_q == StableLast) state_d = StRelSys;
         end
         StRelSys: begin
            if (!lock_q) lost = 1'b1;
            else if (cnt_q == GapLast) state_d = StRelSym;
         end
         StRelSym: begin
            if (!lock_q) lost = 1'b1;
            else if (cnt_q == GapLast) state_d = StRelSer;
         end
         StRelSer: begin
            if (!lock_q) lost = 1'b1;
            else state_d = StDacWait;
         end
         StDacWait: begin
            if (!lock_q) lost = 1'b1;
            else if (cnt_q == DacLast) state_d = StRun;
         end
         StRun: if (!lock_q) lost = 1'b1;
         StFault: begin
            if (CLR_FAULT) begin
               retry_d = '0;
               state_d = StRstAssert;
            end
         end
         default: state_d = StRstAssert;
      endcase

      if (lost) begin
         state_d = StRstAssert;
         if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
      end

      // The cycle that enters STABLE already saw lock high, so it counts as the first.
      if (state_d != state_q) cnt_d = (state_d == StStable) ? CntW'(1) : '0;
      if (state_d == StRun && state_q != StRun) retry_d = '0;

      mmcm_rst_d  = (state_d == StRstAssert) || (state_d == StFault);
      sys_rst_n_d = (state_d >= StRelSys) && (state_d <= StRun);
      sym_rst_n_d = (state_d >= StRelSym) && (state_d <= StRun);
      ser_rst_n_d = (state_d >= StRelSer) && (state_d <= StRun);
      dac_en_d    = (state_d == StRun);
      ready_d     = (state_d == StRun);
      fault_d     = (state_d == StFault);
   end

   always_ff @(posedge SYS_CLK or negedge A_GLB_RST_N) begin
      if (!A_GLB_RST_N) begin
         lock_meta_q <= 1'b0;
         lock_q      <= 1'b0;
         state_q     <= StRstAssert;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_q      <= 8'd0;
         mmcm_rst_q  <= 1'b1;
         sys_rst_n_q <= 1'b0;
         sym_rst_n_q <= 1'b0;
         ser_rst_n_q <= 1'b0;
         dac_en_q    <= 1'b0;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         lock_meta_q <= LOCKED;
         lock_q      <= lock_meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         mmcm_rst_q  <= mmcm_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         sym_rst_n_q <= sym_rst_n_d;
         ser_rst_n_q <= ser_rst_n_d;
         dac_en_q    <= dac_en_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

   assign MMCM_RST       = mmcm_rst_q;
   assign SYS_RST_N      = sys_rst_n_q;
   assign SYM_RST_N      = sym_rst_n_q;
   assign SER_RST_N      = ser_rst_n_q;
   assign DAC_CLK_ENABLE = dac_en_q;
   assign CLK_READY      = ready_q;
   assign FAULT          = fault_q;
   assign LOSS_CNT       = loss_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer: default-parameter instance for timing scenarios and a
// small-parameter instance for LOSS_CNT saturation.
module tb_clk_rst_sequencer;

   logic       SYS_CLK;
   logic       rst_n, locked, clr;
   logic       mmcm, sys, sym, ser, dac, ready, fault;
   logic [7:0] loss;
   logic       s_rst_n, s_locked;
   logic       s_mmcm, s_sys, s_sym, s_ser, s_dac, s_ready, s_fault;
   logic [7:0] s_loss;

   int n_cmp = 0;
   int n_mis = 0;
   int falls, fault_at, k;
   logic prev_mmcm, mmcm_seen, to_flag;

   clk_rst_sequencer u_dut (
      .SYS_CLK(SYS_CLK), .A_GLB_RST_N(rst_n), .LOCKED(locked), .CLR_FAULT(clr),
      .MMCM_RST(mmcm), .SYS_RST_N(sys), .SYM_RST_N(sym), .SER_RST_N(ser),
      .DAC_CLK_ENABLE(dac), .CLK_READY(ready), .FAULT(fault), .LOSS_CNT(loss)
   );

   clk_rst_sequencer #(
      .MMCM_RST_CYCLES(2), .LOCK_TIMEOUT(16), .LOCK_STABLE_CYCLES(2),
      .STAGE_GAP(2), .DAC_EN_DELAY(2), .MAX_RETRY(3)
   ) u_sat (
      .SYS_CLK(SYS_CLK), .A_GLB_RST_N(s_rst_n), .LOCKED(s_locked), .CLR_FAULT(1'b0),
      .MMCM_RST(s_mmcm), .SYS_RST_N(s_sys), .SYM_RST_N(s_sym), .SER_RST_N(s_ser),
      .DAC_CLK_ENABLE(s_dac), .CLK_READY(s_ready), .FAULT(s_fault), .LOSS_CNT(s_loss)
   );

   initial SYS_CLK = 1'b0;
   always #5 SYS_CLK = ~SYS_CLK;

   task automatic step(input int n);
      repeat (n) @(posedge SYS_CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Walks the release chain from a LOCKED rise just applied; expects a clean run to RUN.
   task automatic full_release(input string tag);
      step(257);
      chk({tag, "_sys_pre"}, sys, 1'b0);
      step(1);
      chk({tag, "_sys_rise"}, sys, 1'b1);
      chk({tag, "_sym_order"}, sym, 1'b0);
      step(15);
      chk({tag, "_sym_pre"}, sym, 1'b0);
      step(1);
      chk({tag, "_sym_rise"}, sym, 1'b1);
      chk({tag, "_ser_order"}, ser, 1'b0);
      step(15);
      chk({tag, "_ser_pre"}, ser, 1'b0);
      step(1);
      chk({tag, "_ser_rise"}, ser, 1'b1);
      step(31);
      chk({tag, "_dac_pre"}, dac, 1'b0);
      chk({tag, "_rdy_pre"}, ready, 1'b0);
      step(1);
      chk({tag, "_dac_rise"}, dac, 1'b1);
      chk({tag, "_rdy_rise"}, ready, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; locked = 1'b0; clr = 1'b0;
      s_rst_n = 1'b0; s_locked = 1'b0;

      // Reset values
      step(3);
      chk("rst_mmcm", mmcm, 1'b1);
      chk("rst_sys", sys, 1'b0);
      chk("rst_sym", sym, 1'b0);
      chk("rst_ser", ser, 1'b0);
      chk("rst_dac", dac, 1'b0);
      chk("rst_ready", ready, 1'b0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_loss", loss, 8'd0);

      // Nominal: MMCM_RST held 8 cycles, LOCKED 20 cycles after it falls
      rst_n = 1'b1;
      step(7);
      chk("nom_mmcm_hold", mmcm, 1'b1);
      step(1);
      chk("nom_mmcm_fall", mmcm, 1'b0);
      step(20);
      locked = 1'b1;
      full_release("nom");
      chk("nom_loss", loss, 8'd0);
      chk("nom_fault", fault, 1'b0);

      // Lock loss in RUN
      locked = 1'b0;
      step(3);
      chk("loss_sys", sys, 1'b0);
      chk("loss_sym", sym, 1'b0);
      chk("loss_ser", ser, 1'b0);
      chk("loss_dac", dac, 1'b0);
      chk("loss_ready", ready, 1'b0);
      chk("loss_cnt", loss, 8'd1);
      chk("loss_mmcm", mmcm, 1'b1);
      step(7);
      chk("loss_mmcm_hold", mmcm, 1'b1);
      step(1);
      chk("loss_mmcm_fall", mmcm, 1'b0);
      locked = 1'b1;
      full_release("relock");
      chk("relock_loss", loss, 8'd1);

      // One-cycle glitch while in STABLE
      rst_n = 1'b0; locked = 1'b0;
      step(3);
      chk("rst2_loss", loss, 8'd0);
      rst_n = 1'b1;
      step(8);
      chk("gl_mmcm_fall", mmcm, 1'b0);
      locked = 1'b1;
      step(100);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      mmcm_seen = 1'b0;
      for (int i = 0; i < 257; i++) begin
         step(1);
         mmcm_seen = mmcm_seen | mmcm;
      end
      chk("gl_sys_pre", sys, 1'b0);
      step(1);
      chk("gl_sys_rise", sys, 1'b1);
      chk("gl_no_mmcm", mmcm_seen, 1'b0);

      // Asynchronous reset in REL_SYM
      step(16);
      chk("ar_sym_rise", sym, 1'b1);
      step(5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_sys", sys, 1'b0);
      chk("ar_sym", sym, 1'b0);
      chk("ar_mmcm", mmcm, 1'b1);
      step(1);
      rst_n = 1'b1;
      step(7);
      chk("ar_mmcm_hold", mmcm, 1'b1);
      step(1);
      chk("ar_mmcm_fall", mmcm, 1'b0);

      // Never locks: four attempts then FAULT; stray CLR_FAULT in WAIT_LOCK is ignored
      rst_n = 1'b0; locked = 1'b0;
      step(2);
      rst_n = 1'b1;
      falls = 0; fault_at = 0; prev_mmcm = 1'b1;
      for (int c = 1; c <= 20000; c++) begin
         step(1);
         clr = (c == 5000);
         if (prev_mmcm && !mmcm) falls++;
         prev_mmcm = mmcm;
         if (fault) begin
            fault_at = c;
            break;
         end
      end
      clr = 1'b0;
      chk("nl_falls", falls, 4);
      chk("nl_fault_cycle", fault_at, 16416);
      step(10);
      chk("nl_fault_hold", fault, 1'b1);
      chk("nl_fault_mmcm", mmcm, 1'b1);
      chk("nl_fault_sys", sys, 1'b0);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("clr_fault", fault, 1'b0);
      chk("clr_mmcm", mmcm, 1'b1);
      step(7);
      chk("clr_mmcm_hold", mmcm, 1'b1);
      step(1);
      chk("clr_mmcm_fall", mmcm, 1'b0);

      // LOSS_CNT saturation on the small-parameter instance
      s_rst_n = 1'b1;
      to_flag = 1'b0;
      for (int i = 0; i < 300; i++) begin
         s_locked = 1'b1;
         k = 0;
         while (!s_sys && k < 60) begin
            step(1);
            k++;
         end
         if (!s_sys) to_flag = 1'b1;
         s_locked = 1'b0;
         k = 0;
         while (s_sys && k < 10) begin
            step(1);
            k++;
         end
         if (s_sys) to_flag = 1'b1;
      end
      step(2);
      chk("sat_progress", to_flag, 1'b0);
      chk("sat_loss_cnt", s_loss, 8'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
